lfsr_burst_arbiter: RTL and testbench
=====================================

// Module: lfsr_burst_arbiter
// PURPOSE
//  Shares one 8-bit Fibonacci LFSR (taps 7,5,4,3) among NUM_REQ requesters.
//  Each request carries a seed and a burst length; the block arbitrates round-robin,
//  loads the seed, then streams the LFSR states over a valid/ready output.
//  Sits between the pattern/test clients and the LFSR datapath.
// PARAMETERS
//  NUM_REQ        2       number of requesters (>=2)
//  LEN_W          8       width of burst length field (max burst 2^LEN_W-1 words)
//  ZERO_SEED_SUB  8'hD3   seed substituted when a requester supplies 8'h00 (lock-up state)
// PORTS
//  clk        in   1              rising-edge clock
//  rst        in   1              asynchronous, active-high reset
//  req_valid  in   NUM_REQ        per-requester request pending
//  req_seed   in   8*NUM_REQ      seed, requester i at [8*i+:8]
//  req_len    in   LEN_W*NUM_REQ  burst length in words, requester i at [LEN_W*i+:LEN_W]
//  req_ready  out  NUM_REQ        one-hot grant; handshake = req_valid[i] & req_ready[i]
//  abort      in   1              terminate current burst
//  out_valid  out  1              out_data valid
//  out_data   out  8              current LFSR state
//  out_id     out  ID_W           index of requester owning the burst, ID_W = max(1,$clog2(NUM_REQ))
//  out_last   out  1              final word of the burst
//  out_ready  in   1              sink accepts word
//  busy       out  1              burst in progress (state RUN)
// BEHAVIOUR
//  - Reset: state IDLE, rr_ptr=0, lfsr=0, count=0, out_valid=0, out_last=0, out_id=0, busy=0,
//    req_ready=0. Reset is asynchronous and overrides everything.
//  - FSM: IDLE, RUN.
//  - IDLE: req_ready combinational: one-hot on first valid index searching rr_ptr, rr_ptr+1, ...
//    (mod NUM_REQ); all zero if none valid or abort=1. On handshake from requester g:
//    lfsr <= (seed==0 ? ZERO_SEED_SUB : seed), count <= len, out_id <= g,
//    rr_ptr <= (g+1) mod NUM_REQ; state <= RUN if len!=0, else remain IDLE (request consumed,
//    no output words).
//  - RUN: out_valid=1, out_data=lfsr, out_last=(count==1), req_ready=0.
//    On out_valid&out_ready: if count==1 -> state IDLE; else lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]},
//    count <= count-1. Without handshake out_data/out_last/out_id stay stable.
//  - Latency: first word valid the cycle after request handshake; one IDLE bubble between bursts.
//  - abort in RUN: state <= IDLE next edge, no out_last issued; a handshake in the abort cycle
//    counts as delivered. abort in IDLE: blocks grants that cycle only.
//  - Requesters must hold req_valid/seed/len until handshake; req_valid must not depend on req_ready.
//  - count never wraps: decrement only when count>=2.
// STRUCTURE
//  - lfsr_pkg: LFSR_W=8, TAP mask 8'b1011_1000, ZERO_SEED_SUB default, state enum {IDLE,RUN}.
//  - Sub-module lfsr8_core (clk, rst, load, seed, step, state): holds and advances the register;
//    arbiter/FSM/counter stay in this module.
// TESTING
//  1. req0 seed D3 len 3, out_ready=1 -> out_data D3, A6, 4C on consecutive cycles, out_last
//     on 4C only, out_id=0, busy drops after 4C.
//  2. Same request, out_ready=0 for 3 cycles while A6 shown -> A6/out_last=0 held stable,
//     then 4C follows; no word skipped or repeated.
//  3. req0 and req1 held valid, len 2 each -> grants 0,1,0,1 with one IDLE cycle between
//     bursts; out_id alternates.
//  4. req1 seed 00 len 2 -> output D3, A6. Then req0 len 0 -> req_ready[0] pulses one cycle,
//     out_valid never asserts, busy stays 0.
//  5. seed D3 len 5, assert abort after A6 accepted -> out_valid=0 next cycle, out_last never
//     seen; pending req1 granted afterwards.
//  6. Assert rst asynchronously mid-burst (between edges) -> out_valid, busy, req_ready go 0
//     immediately; after release req1 valid alone is granted and rr_ptr restarts at 0.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared constants, state type and step function for the 8-bit Fibonacci LFSR burst arbiter.
package lfsr_pkg;

   localparam int unsigned LFSR_W = 8;
   // Taps 7,5,4,3 of the Fibonacci feedback.
   localparam logic [LFSR_W-1:0] TAP_MASK = 8'b1011_1000;
   localparam logic [LFSR_W-1:0] DEFAULT_ZERO_SEED_SUB = 8'hD3;

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
      return {s[LFSR_W-2:0], ^(s & TAP_MASK)};
   endfunction

endpackage

// File: rtl/lfsr8_core.sv
// 8-bit Fibonacci LFSR register: parallel load takes priority over a single step.
module lfsr8_core
   import lfsr_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [LFSR_W-1:0] seed,
   input  logic              step,
   output logic [LFSR_W-1:0] state
);

   logic [LFSR_W-1:0] state_q, state_d;

   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = seed;
      end else if (step) begin
         state_d = lfsr_next(state_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= '0;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;

endmodule

// File: rtl/lfsr_burst_arbiter.sv
// Round-robin arbiter that lends one LFSR to NUM_REQ requesters and streams seeded bursts
// over a valid/ready interface.
module lfsr_burst_arbiter
   import lfsr_pkg::*;
#(
   parameter int unsigned       NUM_REQ       = 2,
   parameter int unsigned       LEN_W         = 8,
   parameter logic [LFSR_W-1:0] ZERO_SEED_SUB = DEFAULT_ZERO_SEED_SUB,
   localparam int unsigned      ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [LFSR_W*NUM_REQ-1:0]  req_seed,
   input  logic [LEN_W*NUM_REQ-1:0]   req_len,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic                       abort,
   output logic                       out_valid,
   output logic [LFSR_W-1:0]          out_data,
   output logic [ID_W-1:0]            out_id,
   output logic                       out_last,
   input  logic                       out_ready,
   output logic                       busy
);

   state_e            state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [LEN_W-1:0]  count_q, count_d;

   logic              grant_found;
   logic [ID_W-1:0]   grant_id;
   logic              hs_req, hs_out;
   logic [LFSR_W-1:0] sel_seed, load_seed, lfsr_state;
   logic [LEN_W-1:0]  sel_len;
   logic              lfsr_load, lfsr_step;

   // First valid requester scanning from rr_ptr upwards, wrapping at NUM_REQ.
   always_comb begin
      int unsigned idx;
      grant_found = 1'b0;
      grant_id    = '0;
      idx         = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = 32'(rr_ptr_q) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (!grant_found && req_valid[idx[ID_W-1:0]]) begin
            grant_found = 1'b1;
            grant_id    = idx[ID_W-1:0];
         end
      end
   end

   // Reset is folded in so the grant drops the moment rst rises, not at the next edge.
   always_comb begin
      req_ready = '0;
      if (state_q == StIdle && !abort && !rst && grant_found) begin
         req_ready[grant_id] = 1'b1;
      end
   end

   assign hs_req    = |(req_valid & req_ready);
   assign hs_out    = (state_q == StRun) && out_ready;
   assign sel_seed  = req_seed[LFSR_W*grant_id +: LFSR_W];
   assign sel_len   = req_len[LEN_W*grant_id +: LEN_W];
   assign load_seed = (sel_seed == '0) ? ZERO_SEED_SUB : sel_seed;

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      id_d      = id_q;
      count_d   = count_q;
      lfsr_load = 1'b0;
      lfsr_step = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (hs_req) begin
               lfsr_load = 1'b1;
               count_d   = sel_len;
               id_d      = grant_id;
               if (32'(grant_id) == NUM_REQ - 1) begin
                  rr_ptr_d = '0;
               end else begin
                  rr_ptr_d = grant_id + 1'b1;
               end
               // A zero-length request is consumed without producing words.
               if (sel_len != '0) begin
                  state_d = StRun;
               end
            end
         end
         StRun: begin
            if (hs_out) begin
               if (count_q == LEN_W'(1)) begin
                  state_d = StIdle;
               end else if (count_q >= LEN_W'(2)) begin
                  lfsr_step = 1'b1;
                  count_d   = count_q - 1'b1;
               end
            end
            if (abort) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         rr_ptr_q <= '0;
         id_q     <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         id_q     <= id_d;
         count_q  <= count_d;
      end
   end

   lfsr8_core u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .load  (lfsr_load),
      .seed  (load_seed),
      .step  (lfsr_step),
      .state (lfsr_state)
   );

   assign out_valid = (state_q == StRun);
   assign busy      = (state_q == StRun);
   assign out_data  = lfsr_state;
   assign out_id    = id_q;
   assign out_last  = (state_q == StRun) && (count_q == LEN_W'(1));

endmodule

// File: tb/tb_lfsr_burst_arbiter.sv
// Bench for lfsr_burst_arbiter: directed scenarios plus random traffic checked against a
// transaction-level model (per-burst word lists, round-robin pointer as an integer).
module tb_lfsr_burst_arbiter;

   localparam int N  = 3;
   localparam int LW = 8;
   localparam int IW = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req_valid;
   logic [8*N-1:0]    req_seed;
   logic [LW*N-1:0]   req_len;
   logic [N-1:0]      req_ready;
   logic              abort;
   logic              out_valid;
   logic [7:0]        out_data;
   logic [IW-1:0]     out_id;
   logic              out_last;
   logic              out_ready;
   logic              busy;

   always #5 clk = ~clk;

   lfsr_burst_arbiter #(
      .NUM_REQ       (N),
      .LEN_W         (LW),
      .ZERO_SEED_SUB (8'hD3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_seed  (req_seed),
      .req_len   (req_len),
      .req_ready (req_ready),
      .abort     (abort),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_id    (out_id),
      .out_last  (out_last),
      .out_ready (out_ready),
      .busy      (busy)
   );

   int n_checks = 0;
   int n_bad    = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Requester and sink intent.
   bit         r_valid[N];
   logic [7:0] r_seed[N];
   int         r_len[N];
   bit         t_ready;
   bit         t_abort;

   // Reference model.
   bit         m_busy;
   int         m_ptr;
   int         m_id;
   logic [7:0] m_q[$];

   function automatic logic [7:0] ref_next(input logic [7:0] x);
      return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
   endfunction

   task automatic drive_inputs();
      for (int i = 0; i < N; i++) begin
         req_valid[i]         = r_valid[i];
         req_seed[8*i +: 8]   = r_seed[i];
         req_len[LW*i +: LW]  = r_len[i][LW-1:0];
      end
      out_ready = t_ready;
      abort     = t_abort;
   endtask

   task automatic set_req(input int i, input logic [7:0] seed, input int len);
      r_valid[i] = 1'b1;
      r_seed[i]  = seed;
      r_len[i]   = len;
   endtask

   task automatic model_reset();
      m_busy = 1'b0;
      m_ptr  = 0;
      m_id   = 0;
      m_q.delete();
   endtask

   task automatic step_cycle();
      int         g;
      logic [N-1:0] exp_rdy;
      logic [7:0] w;
      @(negedge clk);
      drive_inputs();
      #1;
      g = -1;
      if (!m_busy && !t_abort) begin
         for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (g < 0 && r_valid[idx]) g = idx;
         end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check_val("req_ready", 32'(req_ready), 32'(exp_rdy));
      check_val("out_valid", 32'(out_valid), 32'(m_busy));
      check_val("busy", 32'(busy), 32'(m_busy));
      check_val("out_last", 32'(out_last), 32'(m_busy && m_q.size() == 1));
      check_val("out_id", 32'(out_id), 32'(m_id));
      if (m_busy) check_val("out_data", 32'(out_data), 32'(m_q[0]));
      if (m_busy) begin
         if (t_ready) void'(m_q.pop_front());
         if (t_abort || m_q.size() == 0) begin
            m_busy = 1'b0;
            m_q.delete();
         end
      end else if (g >= 0) begin
         m_ptr = (g + 1) % N;
         m_id  = g;
         w     = (r_seed[g] == 8'h00) ? 8'hD3 : r_seed[g];
         m_q.delete();
         for (int i = 0; i < r_len[g]; i++) begin
            m_q.push_back(w);
            w = ref_next(w);
         end
         m_busy     = (r_len[g] != 0);
         r_valid[g] = 1'b0;
      end
   endtask

   task automatic run(input int n, input bit rdy, input bit ab);
      t_ready = rdy;
      t_abort = ab;
      for (int i = 0; i < n; i++) step_cycle();
      t_abort = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         r_valid[i] = 1'b1;
         r_seed[i]  = 8'h5A;
         r_len[i]   = 3;
      end
      t_ready = 1'b1;
      t_abort = 1'b0;
      rst     = 1'b1;
      drive_inputs();
      model_reset();
      @(posedge clk);
      #1;
      check_val("rst_req_ready", 32'(req_ready), 32'h0);
      check_val("rst_out_valid", 32'(out_valid), 32'h0);
      check_val("rst_busy", 32'(busy), 32'h0);
      check_val("rst_out_last", 32'(out_last), 32'h0);
      check_val("rst_out_id", 32'(out_id), 32'h0);
      check_val("rst_out_data", 32'(out_data), 32'h0);
      for (int i = 0; i < N; i++) r_valid[i] = 1'b0;
      drive_inputs();
      @(posedge clk);
      #2 rst = 1'b0;

      // Plain burst, then a stalled one.
      set_req(0, 8'hD3, 3);
      run(5, 1'b1, 1'b0);
      set_req(0, 8'hD3, 3);
      run(2, 1'b1, 1'b0);
      run(3, 1'b0, 1'b0);
      run(3, 1'b1, 1'b0);

      // Two requesters held valid: alternating grants.
      for (int c = 0; c < 14; c++) begin
         if (!r_valid[0]) set_req(0, 8'h11, 2);
         if (!r_valid[1]) set_req(1, 8'h5A, 2);
         run(1, 1'b1, 1'b0);
      end
      run(10, 1'b1, 1'b0);

      // Zero seed substitution and zero-length request.
      set_req(1, 8'h00, 2);
      run(4, 1'b1, 1'b0);
      set_req(0, 8'h77, 0);
      run(3, 1'b1, 1'b0);

      // Abort after two words accepted; pending requester follows.
      set_req(0, 8'hD3, 5);
      run(3, 1'b1, 1'b0);
      set_req(1, 8'h42, 2);
      run(1, 1'b0, 1'b1);
      run(5, 1'b1, 1'b0);

      // Asynchronous reset mid-burst.
      set_req(1, 8'h99, 4);
      run(3, 1'b1, 1'b0);
      @(negedge clk);
      #2;
      set_req(2, 8'h31, 2);
      drive_inputs();
      rst = 1'b1;
      #1;
      check_val("arst_out_valid", 32'(out_valid), 32'h0);
      check_val("arst_busy", 32'(busy), 32'h0);
      check_val("arst_req_ready", 32'(req_ready), 32'h0);
      check_val("arst_out_last", 32'(out_last), 32'h0);
      model_reset();
      for (int i = 0; i < N; i++) r_valid[i] = 1'b0;
      drive_inputs();
      @(posedge clk);
      #2 rst = 1'b0;
      set_req(1, 8'hA5, 2);
      set_req(2, 8'h3C, 2);
      run(8, 1'b1, 1'b0);

      // Random traffic.
      for (int c = 0; c < 2500; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!r_valid[i] && $urandom_range(0, 9) < 3) begin
               set_req(i, ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
                       ($urandom_range(0, 9) == 0) ? int'($urandom_range(7, 40))
                                                   : int'($urandom_range(0, 6)));
            end
         end
         t_ready = ($urandom_range(0, 3) != 0);
         t_abort = ($urandom_range(0, 24) == 0);
         step_cycle();
      end

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
